// File: rtl/hub75_pkg.sv
// Shared definitions for the FTDI receive front end and the HUB75 display side.
//   SYNC_BYTE  : frame-start marker; never sent by the host as pixel data
//   NUM_PIXELS : pixels per frame, addressed 0..NUM_PIXELS-1
//   ADDR_W     : frame-buffer address width
//   pixel_t    : one 24-bit {r,g,b} frame-buffer word, r in [23:16]
package hub75_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hFF;
    localparam int         NUM_PIXELS = 8192;
    localparam int         ADDR_W     = 13;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_OE,
        BUS_READ
    } bus_state_e;

    typedef enum logic [1:0] {
        P_HUNT,
        P_R,
        P_G,
        P_B
    } parse_state_e;

endpackage

// File: rtl/ftdi_fifo_if.sv
// FT232H 245-synchronous FIFO read handshake (RXF#/OE#/RD#).
//   clk_60       : FTDI CLKOUT, rising edge
//   rst_n        : asynchronous active-low reset
//   data_i       : FTDI data bus
//   rxf_n_i      : low = FTDI has data
//   oe_n_o       : low = FTDI drives the bus
//   rd_n_o       : low = byte accepted on each edge while rxf_n_i is low
//   byte_o       : last byte taken
//   byte_valid_o : one-cycle strobe, byte_o is new
//
// state    | meaning
// BUS_IDLE | bus released, waiting for rxf_n_i low
// BUS_OE   | oe_n asserted, one turnaround cycle before reading
// BUS_READ | rd_n asserted, one byte per edge while rxf_n_i is low
module ftdi_fifo_if
    import hub75_pkg::*;
(
    input  logic       clk_60,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic       rxf_n_i,
    output logic       oe_n_o,
    output logic       rd_n_o,
    output logic [7:0] byte_o,
    output logic       byte_valid_o
);

    bus_state_e state_q;
    logic       oe_n_q;
    logic       rd_n_q;
    logic [7:0] byte_q;
    logic       byte_valid_q;

    always_ff @(posedge clk_60 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BUS_IDLE;
            oe_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            case (state_q)
                BUS_IDLE: begin
                    if (!rxf_n_i) begin
                        oe_n_q  <= 1'b0;
                        state_q <= BUS_OE;
                    end
                end
                BUS_OE: begin
                    rd_n_q  <= 1'b0;
                    state_q <= BUS_READ;
                end
                BUS_READ: begin
                    // A byte on the edge where rxf_n rises is not valid data.
                    if (rxf_n_i) begin
                        rd_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        state_q <= BUS_IDLE;
                    end else if (!rd_n_q) begin
                        byte_q       <= data_i;
                        byte_valid_q <= 1'b1;
                    end
                end
                default: begin
                    rd_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    state_q <= BUS_IDLE;
                end
            endcase
        end
    end

    assign oe_n_o       = oe_n_q;
    assign rd_n_o       = rd_n_q;
    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;

endmodule

// File: rtl/ftdi_sync_rx.sv
// FT232H receive front end feeding the HUB75 frame-buffer write port.
// Hunts for SYNC_BYTE, packs the following R,G,B bytes into pixels written
// to sequential addresses, and pulses frame_done on the last pixel.
//   clk_60, rst_n           : FTDI clock, async active-low reset
//   ftdi_data, ftdi_rxf_n   : FTDI FIFO read side
//   ftdi_oe_n, ftdi_rd_n    : FTDI handshake outputs
//   fb_we, fb_addr, fb_data : frame-buffer write port (always accepts)
//   frame_done              : pulse with the write of address NUM_PIXELS-1
//   frame_err               : pulse when SYNC_BYTE arrives mid-frame
//
// state  | meaning
// P_HUNT | discarding bytes until SYNC_BYTE
// P_R    | expecting red byte of next pixel
// P_G    | expecting green byte
// P_B    | expecting blue byte; pixel is written once it arrives
module ftdi_sync_rx #(
    parameter int NUM_PIXELS = hub75_pkg::NUM_PIXELS,
    parameter int ADDR_W     = hub75_pkg::ADDR_W
) (
    input  logic              clk_60,
    input  logic              rst_n,
    input  logic [7:0]        ftdi_data,
    input  logic              ftdi_rxf_n,
    output logic              ftdi_oe_n,
    output logic              ftdi_rd_n,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [23:0]       fb_data,
    output logic              frame_done,
    output logic              frame_err
);
    import hub75_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    logic [7:0] rx_byte;
    logic       rx_valid;

    ftdi_fifo_if u_fifo_if (
        .clk_60       (clk_60),
        .rst_n        (rst_n),
        .data_i       (ftdi_data),
        .rxf_n_i      (ftdi_rxf_n),
        .oe_n_o       (ftdi_oe_n),
        .rd_n_o       (ftdi_rd_n),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid)
    );

    parse_state_e      pstate_q;
    logic [7:0]        r_q;
    logic [7:0]        g_q;
    pixel_t            fb_data_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [ADDR_W-1:0] fb_addr_d;
    logic              fb_we_q;
    logic              frame_done_q;
    logic              frame_err_q;

    // fb_addr holds the address of the current write and moves on in the
    // cycle after the strobe, wrapping to 0 after the last pixel.
    always_comb begin
        fb_addr_d = fb_addr_q;
        if (fb_we_q) begin
            fb_addr_d = (fb_addr_q == LAST_ADDR) ? '0 : fb_addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_60 or negedge rst_n) begin
        if (!rst_n) begin
            pstate_q     <= P_HUNT;
            r_q          <= '0;
            g_q          <= '0;
            fb_data_q    <= '0;
            fb_addr_q    <= '0;
            fb_we_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            fb_we_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            fb_addr_q    <= fb_addr_d;
            if (rx_valid) begin
                if (rx_byte == SYNC_BYTE) begin
                    // Sync restarts the frame from any state; only mid-frame is an error.
                    frame_err_q <= (pstate_q != P_HUNT);
                    fb_addr_q   <= '0;
                    pstate_q    <= P_R;
                end else begin
                    case (pstate_q)
                        P_HUNT: pstate_q <= P_HUNT;
                        P_R: begin
                            r_q      <= rx_byte;
                            pstate_q <= P_G;
                        end
                        P_G: begin
                            g_q      <= rx_byte;
                            pstate_q <= P_B;
                        end
                        P_B: begin
                            fb_we_q      <= 1'b1;
                            fb_data_q    <= {r_q, g_q, rx_byte};
                            frame_done_q <= (fb_addr_q == LAST_ADDR);
                            pstate_q     <= (fb_addr_q == LAST_ADDR) ? P_HUNT : P_R;
                        end
                        default: pstate_q <= P_HUNT;
                    endcase
                end
            end
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule
